clk_edge_monitor: RTL and testbench

Consumer-side companion to the clock divider. It takes a slow, possibly asynchronous clock-like signal, such as a divided clock (mouseclk, segclk) or an external device clock, into the 100 MHz master domain. It synchronises the signal and emits single-cycle rise/fall enable strobes. It also measures the period in master-clock cycles and reports lock and loss-of-clock, so downstream logic uses clock enables instead of derived clocks.

---
 rtl/clk_edge_monitor_pkg.sv | 15 +
 rtl/clk_edge_monitor_if.sv | 25 ++
 rtl/sync_edge_det.sv | 74 +++++++
 rtl/clk_edge_monitor.sv | 89 ++++++++
 tb/tb_clk_edge_monitor.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/clk_edge_monitor_pkg.sv
// Shared types and default parameter values for the clock-edge monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned PERIOD_W_DEF       = 24;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 12_500_000;
  localparam int unsigned FILTER_LEN_DEF     = 4;

endpackage

// File: rtl/clk_edge_monitor_if.sv
// Monitor bundle: slow clock input plus strobes, period and lock status.
interface clk_edge_monitor_if
  import clk_mon_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
);
  logic                sclk_in;
  logic                rise_stb;
  logic                fall_stb;
  logic [PERIOD_W-1:0] period;
  logic                period_vld;
  logic                locked;
  logic                lost;

  // master: the monitor itself; slave: the consumer that supplies sclk_in
  modport master (
    input  sclk_in,
    output rise_stb, fall_stb, period, period_vld, locked, lost
  );

  modport slave (
    output sclk_in,
    input  rise_stb, fall_stb, period, period_vld, locked, lost
  );
endinterface

// File: rtl/sync_edge_det.sv
// Synchroniser plus registered rise/fall strobes; optional glitch filter
// enabled by defining GLITCH_FILTER_EN.
module sync_edge_det
  import clk_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic sclk_in,
  output logic rise_stb,
  output logic fall_stb
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_chk_filt
    $error("FILTER_LEN must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   prev;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sclk_in};
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FW-1:0] fcnt;
  logic          accepted;

  // A new level is adopted after FILTER_LEN consecutive samples that differ
  // from the accepted one; any return to the accepted level restarts the run.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fcnt     <= '0;
      accepted <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == accepted) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 1)) begin
      fcnt     <= '0;
      accepted <= sync[SYNC_STAGES-1];
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign level = accepted;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev     <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      prev     <= level;
      rise_stb <= level & ~prev;
      fall_stb <= ~level & prev;
    end
  end

endmodule

// File: rtl/clk_edge_monitor.sv
// Turns a slow asynchronous clock into rise/fall enables and measures its
// period with lock / loss-of-clock reporting. Optional: GLITCH_FILTER_EN.
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned PERIOD_W       = PERIOD_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  clk_edge_monitor_if.master mon
);

  if (TIMEOUT_CYCLES < 1 || 64'(TIMEOUT_CYCLES) >= (64'd1 << PERIOD_W) - 64'd1) begin : g_chk_to
    $error("TIMEOUT_CYCLES out of range for PERIOD_W");
  end

  localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT_CYCLES - 1);

  logic                rise;
  logic                fall;
  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_q;
  logic                period_vld_q;
  logic                locked_q;
  logic                lost_q;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync (
    .clk      (clk),
    .clr_n    (clr_n),
    .sclk_in  (mon.sclk_in),
    .rise_stb (rise),
    .fall_stb (fall)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      period_vld_q <= 1'b0;
      lost_q       <= 1'b0;

      if (rise) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end

      // A rise on the timeout cycle takes priority over declaring loss.
      unique case (state)
        IDLE: begin
          if (rise) state <= ARMED;
        end
        ARMED, LOCKED: begin
          if (rise) begin
            period_q     <= cnt + 1'b1;
            period_vld_q <= 1'b1;
            locked_q     <= 1'b1;
            state        <= LOCKED;
          end else if (cnt == TO_LAST) begin
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mon.rise_stb   = rise;
  assign mon.fall_stb   = fall;
  assign mon.period     = period_q;
  assign mon.period_vld = period_vld_q;
  assign mon.locked     = locked_q;
  assign mon.lost       = lost_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor; adds glitch-filter scenario when
// GLITCH_FILTER_EN is defined.
module tb_clk_edge_monitor;
  import clk_mon_pkg::*;

  localparam int T = 100;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic clr_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clk_edge_monitor_if #(.PERIOD_W(24)) bus ();

  clk_edge_monitor #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .mon   (bus.master)
  );

  task automatic do_reset();
    @(negedge clk);
    clr_n       = 1'b0;
    bus.sclk_in = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] got;
    clr_n       = 1'b0;
    bus.sclk_in = 1'b0;
    #1;
    got = {bus.rise_stb, bus.fall_stb, bus.period_vld, bus.lost, bus.locked};
    checks++;
    if (got !== 5'b0 || bus.period !== 24'd0) begin
      errors++;
      $display("FAIL reset_vals got r/f/v/l/k=%b period=%0d want 00000 0", got, bus.period);
    end
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      got = {bus.rise_stb, bus.fall_stb, bus.period_vld, bus.lost, bus.locked};
      checks++;
      if (got !== 5'b0 || bus.period !== 24'd0) begin
        errors++;
        $display("FAIL idle_low cyc=%0d got r/f/v/l/k=%b period=%0d want 00000 0", i, got, bus.period);
      end
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL idle_state got %0d want %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_square();
    logic [4:0] got, exp;
    int s;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      bus.sclk_in = ((i % 40) < 20);
      @(negedge clk);
      s   = i + 1;
      exp = {(s >= LAT) && ((s - LAT) % 40 == 0),
             (s >= LAT + 20) && ((s - LAT - 20) % 40 == 0),
             (s >= LAT + 41) && ((s - LAT - 1) % 40 == 0),
             1'b0,
             (s >= LAT + 41)};
      got = {bus.rise_stb, bus.fall_stb, bus.period_vld, bus.lost, bus.locked};
      checks++;
      if (got !== exp || bus.period !== ((s >= LAT + 41) ? 24'd40 : 24'd0)) begin
        errors++;
        $display("FAIL square s=%0d got r/f/v/l/k=%b period=%0d want %b", s, got, bus.period, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] got, exp;
    logic [23:0] exp_p;
    int s;
    do_reset();
    for (int i = 0; i < 350; i++) begin
      if (i < 100)      bus.sclk_in = ((i % 40) < 20);
      else if (i < 300) bus.sclk_in = 1'b0;
      else              bus.sclk_in = (((i - 300) % 40) < 20);
      @(negedge clk);
      s   = i + 1;
      exp = {(s == LAT) || (s == LAT + 40) || (s == LAT + 80) || (s == LAT + 300) || (s == LAT + 340),
             (s == LAT + 20) || (s == LAT + 60) || (s == LAT + 100) || (s == LAT + 320),
             (s == LAT + 41) || (s == LAT + 81) || (s == LAT + 341),
             (s == LAT + 80 + T + 1),
             ((s >= LAT + 41) && (s < LAT + 80 + T + 1)) || (s >= LAT + 341)};
      exp_p = (s >= LAT + 41) ? 24'd40 : 24'd0;
      got = {bus.rise_stb, bus.fall_stb, bus.period_vld, bus.lost, bus.locked};
      checks++;
      if (got !== exp || bus.period !== exp_p) begin
        errors++;
        $display("FAIL timeout s=%0d got r/f/v/l/k=%b period=%0d want %b %0d", s, got, bus.period, exp, exp_p);
      end
      if (s == LAT + 302) begin
        checks++;
        if (dut.state !== ARMED) begin
          errors++;
          $display("FAIL rearm_state got %0d want %0d", dut.state, ARMED);
        end
      end
    end
  endtask

  task automatic test_period_eq_timeout();
    logic [4:0] got, exp;
    int s;
    do_reset();
    for (int i = 0; i < 450; i++) begin
      bus.sclk_in = ((i % 100) < 50);
      @(negedge clk);
      s   = i + 1;
      exp = {(s >= LAT) && ((s - LAT) % 100 == 0),
             (s >= LAT + 50) && ((s - LAT - 50) % 100 == 0),
             (s >= LAT + 101) && ((s - LAT - 1) % 100 == 0),
             1'b0,
             (s >= LAT + 101)};
      got = {bus.rise_stb, bus.fall_stb, bus.period_vld, bus.lost, bus.locked};
      checks++;
      if (got !== exp || bus.period !== ((s >= LAT + 101) ? 24'd100 : 24'd0)) begin
        errors++;
        $display("FAIL period_eq_to s=%0d got r/f/v/l/k=%b period=%0d want %b", s, got, bus.period, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    int s;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      bus.sclk_in = ((i % 40) < 20);
      @(negedge clk);
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.period !== 24'd40) begin
      errors++;
      $display("FAIL pre_clr got locked=%b period=%0d want 1 40", bus.locked, bus.period);
    end
    #2;
    clr_n       = 1'b0;
    bus.sclk_in = 1'b0;
    #1;
    got = {bus.rise_stb, bus.fall_stb, bus.period_vld, bus.lost, bus.locked};
    checks++;
    if (got !== 5'b0 || bus.period !== 24'd0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL async_clr got r/f/v/l/k=%b period=%0d state=%0d want 00000 0 0", got, bus.period, dut.state);
    end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < LAT + 46; i++) begin
      bus.sclk_in = ((i % 40) < 20);
      @(negedge clk);
      s = i + 1;
      checks++;
      if (bus.locked !== (s >= LAT + 41) || bus.period_vld !== (s == LAT + 41)) begin
        errors++;
        $display("FAIL relock s=%0d got locked=%b vld=%b want %b %b", s, bus.locked, bus.period_vld,
                 (s >= LAT + 41), (s == LAT + 41));
      end
    end
  endtask

`ifdef GLITCH_FILTER_EN
  task automatic test_glitch();
    int s;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.sclk_in = (i < 2);
      @(negedge clk);
      checks++;
      if (bus.rise_stb !== 1'b0 || bus.fall_stb !== 1'b0) begin
        errors++;
        $display("FAIL glitch i=%0d got r=%b f=%b want 0 0", i, bus.rise_stb, bus.fall_stb);
      end
    end
    for (int i = 0; i < 30; i++) begin
      bus.sclk_in = (i < 6);
      @(negedge clk);
      s = i + 1;
      checks++;
      if (bus.rise_stb !== (s == 7) || bus.fall_stb !== (s == 13)) begin
        errors++;
        $display("FAIL pulse6 s=%0d got r=%b f=%b want %b %b", s, bus.rise_stb, bus.fall_stb,
                 (s == 7), (s == 13));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_square();
    test_timeout();
    test_period_eq_timeout();
    test_async_reset();
`ifdef GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
